// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg
//   Shared AHB-Lite encodings for the SRAM responder: transfer type, transfer
//   size, response code and the responder's data-phase state machine.
//   No ports; imported by ahb_lite_wstrb_gen and ahb_lite_sram_slave.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BYTE = 3'd0,
    HALF = 3'd1,
    WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_e;

  // Data-phase states of the responder.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // no transfer in data phase, zero-wait OKAY
    ST_WAIT = 3'd1,  // inserting wait states
    ST_DATA = 3'd2,  // final (ready) cycle of an OKAY data phase
    ST_ERR1 = 3'd3,  // first ERROR cycle, HREADYOUT low
    ST_ERR2 = 3'd4   // second ERROR cycle, HREADYOUT high
  } slave_state_e;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/ahb_lite_wstrb_gen.sv
// ahb_lite_wstrb_gen
//   Combinational byte-lane strobe generator for a little-endian 32-bit bus.
//   Ports:
//     hsize   in  3  transfer size (BYTE/HALF/WORD, anything else gives no lanes)
//     addr_lo in  2  byte address bits [1:0]
//     strb    out 4  one bit per byte lane of HWDATA to commit
module ahb_lite_wstrb_gen
  import ahb_lite_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb
);

  always_comb begin
    strb = 4'b0000;
    case (hsize)
      BYTE:    strb = 4'b0001 << addr_lo;
      HALF:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      WORD:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
//   AHB-Lite responder backed by a word-organised SRAM (MEM_DEPTH x 32 bits).
//   Serves byte/halfword/word reads and writes, inserts WAIT_STATES wait
//   cycles in every OKAY data phase and gives the two-cycle ERROR response
//   for bad size, misalignment or out-of-range addresses.
//   Optional build macro AHB_SLAVE_PRIV_CHECK_EN: non-privileged accesses
//   (HPROT[1]=0) to the upper half of the memory are also errors.
//
//   Handshake: an address phase is taken on a rising edge when
//   HSEL & HREADY & HTRANS[1]; a data phase completes on the rising edge
//   where HREADYOUT is 1. HRDATA/HRESP are meaningful in that final cycle.
//
//   Ports:
//     HCLK, HRESETn          clock, asynchronous active-low reset
//     HSEL, HADDR, HWRITE,   address-phase controls
//     HSIZE, HBURST, HPROT,
//     HTRANS, HMASTLOCK
//     HREADY                 bus-level ready (address phase sampled when 1)
//     HWDATA                 write data (data phase)
//     HRDATA                 read data, 0 outside the final read data cycle
//     HREADYOUT, HRESP       data-phase stall and response
//     state_dbg              current data-phase FSM state
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         HSEL,
  input  logic [31:0]  HADDR,
  input  logic         HWRITE,
  input  logic [2:0]   HSIZE,
  input  logic [2:0]   HBURST,
  input  logic [3:0]   HPROT,
  input  logic [1:0]   HTRANS,
  input  logic         HMASTLOCK,
  input  logic         HREADY,
  input  logic [31:0]  HWDATA,
  output logic [31:0]  HRDATA,
  output logic         HREADYOUT,
  output logic         HRESP,
  output slave_state_e state_dbg
);

  localparam int          IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * MEM_DEPTH);
`ifdef AHB_SLAVE_PRIV_CHECK_EN
  // First byte address of the privileged upper half.
  localparam logic [31:0] PRIV_BASE  = 32'(4 * (MEM_DEPTH / 2));
`endif

  logic [31:0] mem [MEM_DEPTH];

  slave_state_e          state, next_state;
  logic [WAIT_CNT_W-1:0] wait_cnt, next_cnt;
  logic                  dp_write;
  logic [IDX_W-1:0]      dp_idx;
  logic [3:0]            dp_strb;

  logic                  accept;
  logic                  addr_err;
  logic                  load_dp;
  logic [3:0]            addr_strb;
  logic                  unused_inputs;

  // Bus attributes with no effect on this responder.
  assign unused_inputs = ^{HBURST, HMASTLOCK, HTRANS[0], HPROT};

  assign accept = HSEL & HREADY & HTRANS[1];

  ahb_lite_wstrb_gen u_wstrb (
    .hsize   (HSIZE),
    .addr_lo (HADDR[1:0]),
    .strb    (addr_strb)
  );

  // Address-phase error classification.
  always_comb begin
    addr_err = 1'b0;
    if (HSIZE > WORD)                       addr_err = 1'b1;
    if ((HSIZE == HALF) && HADDR[0])        addr_err = 1'b1;
    if ((HSIZE == WORD) && (HADDR[1:0] != 2'b00)) addr_err = 1'b1;
    if (HADDR >= BYTE_LIMIT)                addr_err = 1'b1;
`ifdef AHB_SLAVE_PRIV_CHECK_EN
    if (!HPROT[1] && (HADDR >= PRIV_BASE))  addr_err = 1'b1;
`endif
  end

  // Next state. IDLE, DATA and ERR2 are all ready cycles, so each of them
  // ends its data phase on this edge and may take a new address phase.
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    load_dp    = 1'b0;
    case (state)
      ST_WAIT: begin
        if (wait_cnt == '0) next_state = ST_DATA;
        else                next_cnt   = wait_cnt - 1'b1;
      end
      ST_ERR1: next_state = ST_ERR2;
      default: begin
        next_state = ST_IDLE;
        if (accept) begin
          load_dp = 1'b1;
          if (addr_err) begin
            next_state = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            next_state = ST_WAIT;
            next_cnt   = WAIT_CNT_W'(WAIT_STATES - 1);
          end else begin
            next_state = ST_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_strb  <= 4'b0000;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      if (load_dp) begin
        dp_write <= HWRITE;
        dp_idx   <= HADDR[IDX_W+1:2];
        dp_strb  <= addr_strb;
      end
    end
  end

  // Write commits on the edge that closes the DATA cycle, so a read whose
  // data phase follows immediately sees the new contents.
  always_ff @(posedge HCLK) begin
    if ((state == ST_DATA) && dp_write) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (dp_strb[lane]) mem[dp_idx][8*lane +: 8] <= HWDATA[8*lane +: 8];
      end
    end
  end

  assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
  assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
  assign HRDATA    = ((state == ST_DATA) && !dp_write) ? mem[dp_idx] : 32'h0;
  assign state_dbg = state;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
module tb_ahb_lite_sram_slave;
  import ahb_lite_pkg::*;

  localparam int MEM_DEPTH = 256;
  localparam int NDUT      = 3;

  typedef struct {
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  prot;
  } xfer_t;

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  // ---------------- shared bus ----------------
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata;

  logic [31:0]  hrdata0, hrdata1, hrdata2;
  logic         hrdy0, hrdy1, hrdy2;
  logic         hresp0, hresp1, hresp2;
  slave_state_e st0, st1, st2;

  // Three instances with 0, 2 and 3 wait states; each is alone on its bus,
  // so its HREADY is its own HREADYOUT.
  ahb_lite_sram_slave #(.MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
    .HREADY(hrdy0), .HWDATA(hwdata), .HRDATA(hrdata0), .HREADYOUT(hrdy0), .HRESP(hresp0),
    .state_dbg(st0)
  );
  ahb_lite_sram_slave #(.MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(2)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
    .HREADY(hrdy1), .HWDATA(hwdata), .HRDATA(hrdata1), .HREADYOUT(hrdy1), .HRESP(hresp1),
    .state_dbg(st1)
  );
  ahb_lite_sram_slave #(.MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(3)) u_dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
    .HREADY(hrdy2), .HWDATA(hwdata), .HRDATA(hrdata2), .HREADYOUT(hrdy2), .HRESP(hresp2),
    .state_dbg(st2)
  );

  function automatic int wait_of(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic rdy_of(input int d);
    case (d)
      0:       return hrdy0;
      1:       return hrdy1;
      default: return hrdy2;
    endcase
  endfunction

  function automatic logic resp_of(input int d);
    case (d)
      0:       return hresp0;
      1:       return hresp1;
      default: return hresp2;
    endcase
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    case (d)
      0:       return hrdata0;
      1:       return hrdata1;
      default: return hrdata2;
    endcase
  endfunction

  function automatic logic [31:0] state_of(input int d);
    case (d)
      0:       return 32'(st0);
      1:       return 32'(st1);
      default: return 32'(st2);
    endcase
  endfunction

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Byte-addressed memory image per instance; only bytes that were written
  // are compared on reads.
  logic [7:0] mdl_byte [NDUT][4*MEM_DEPTH];
  bit         mdl_vld  [NDUT][4*MEM_DEPTH];

  function automatic bit exp_err(input xfer_t t);
    int nbytes;
    if (t.size > 3'd2) return 1'b1;
    nbytes = 1 << t.size;
    if ((t.addr % nbytes) != 0) return 1'b1;
    if (t.addr >= 32'(4 * MEM_DEPTH)) return 1'b1;
`ifdef AHB_SLAVE_PRIV_CHECK_EN
    if (!t.prot[1] && ((t.addr / 4) >= 32'(MEM_DEPTH / 2))) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic void model_write(input int d, input xfer_t t);
    int a;
    for (int i = 0; i < (1 << t.size); i++) begin
      a = int'(t.addr) + i;
      mdl_byte[d][a] = t.wdata[8*(a%4) +: 8];
      mdl_vld[d][a]  = 1'b1;
    end
  endfunction

  function automatic void model_read(input int d, input logic [31:0] addr,
                                     output logic [31:0] w, output logic [31:0] m);
    int base;
    base = int'(addr) - (int'(addr) % 4);
    w = 32'h0;
    m = 32'h0;
    for (int j = 0; j < 4; j++) begin
      w[8*j +: 8] = mdl_byte[d][base+j];
      m[8*j +: 8] = mdl_vld[d][base+j] ? 8'hFF : 8'h00;
    end
  endfunction

  // ---------------- driver ----------------
  xfer_t txq[$];

  function automatic xfer_t mk(input logic [1:0] trans, input logic write, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] prot = 4'b0011);
    xfer_t t;
    t.trans = trans; t.write = write; t.size = size;
    t.addr  = addr;  t.wdata = wdata; t.prot = prot;
    return t;
  endfunction

  task automatic drive_idle();
    hsel   = 3'b000;
    htrans = 2'(IDLE);
    hwrite = 1'b0;
    hsize  = 3'(WORD);
    haddr  = 32'h0;
    hprot  = 4'b0011;
  endtask

  task automatic drive_xfer(input int d, input xfer_t t);
    hsel   = 3'b001 << d;
    htrans = t.trans;
    hwrite = t.write;
    hsize  = t.size;
    haddr  = t.addr;
    hprot  = t.prot;
    hburst = 3'd1;
  endtask

  // Plays txq to instance d as a pipelined AHB master and checks every data
  // phase. Everything is driven and sampled on the falling edge.
  task automatic run_q(input int d);
    xfer_t       dp;
    bit          dp_vld;
    int          low;
    int          budget;
    logic        r;
    bit          e;
    logic [31:0] w, m;
    dp_vld = 1'b0;
    low    = 0;
    budget = 0;
    forever begin
      @(negedge HCLK);
      budget++;
      if (budget > 4000) begin
        check("run_timeout", 32'(budget), 32'd0);
        drive_idle();
        break;
      end
      r = rdy_of(d);
      if (dp_vld) begin
        e = exp_err(dp);
        hwdata = dp.wdata;
        if (!r) begin
          low++;
          check("hresp_stall", 32'(resp_of(d)), 32'(e));
          check("rdata_stall", rdata_of(d), 32'h0);
        end else begin
          check("wait_cycles", 32'(low), e ? 32'd1 : 32'(wait_of(d)));
          check("hresp", 32'(resp_of(d)), 32'(e));
          if (!dp.write && !e) begin
            model_read(d, dp.addr, w, m);
            exp_q.push_back(w & m);
            check("rdata", rdata_of(d) & m, exp_q.pop_front());
          end else begin
            check("rdata_zero", rdata_of(d), 32'h0);
            if (dp.write && !e) model_write(d, dp);
          end
          dp_vld = 1'b0;
        end
      end else begin
        check("idle_okay", {30'h0, resp_of(d), r}, 32'h1);
      end
      if (r) begin
        if (txq.size() > 0) begin
          dp = txq.pop_front();
          drive_xfer(d, dp);
          dp_vld = dp.trans[1];
          low    = 0;
        end else begin
          drive_idle();
          break;
        end
      end
    end
  endtask

  task automatic random_q(input int n);
    xfer_t t;
    int    sel;
    for (int i = 0; i < n; i++) begin
      sel     = int'($urandom_range(0, 9));
      t.trans = (sel == 0) ? 2'(BUSY) : (sel == 1) ? 2'(IDLE) : (sel < 6) ? 2'(NONSEQ) : 2'(SEQ);
      t.write = 1'($urandom_range(0, 1));
      sel     = int'($urandom_range(0, 9));
      t.size  = (sel < 3) ? 3'(BYTE) : (sel < 6) ? 3'(HALF) : (sel < 9) ? 3'(WORD)
                                                                       : 3'($urandom_range(3, 7));
      sel     = int'($urandom_range(0, 9));
      if (sel < 6)      t.addr = 32'($urandom_range(0, 63));
      else if (sel < 9) t.addr = 32'($urandom_range(4*MEM_DEPTH - 64, 4*MEM_DEPTH - 1));
      else              t.addr = 32'($urandom_range(4*MEM_DEPTH, 4*MEM_DEPTH + 255));
      // Mostly aligned so that the OKAY path gets most of the traffic.
      if ($urandom_range(0, 4) != 0 && t.size <= 3'd2)
        t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
      t.wdata = $urandom;
      t.prot  = 4'($urandom_range(0, 15));
      txq.push_back(t);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < NDUT; d++)
      for (int a = 0; a < 4*MEM_DEPTH; a++) begin
        mdl_byte[d][a] = 8'h00;
        mdl_vld[d][a]  = 1'b0;
      end
    hburst    = 3'd0;
    hmastlock = 1'b0;
    hwdata    = 32'h0;
    drive_idle();

    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    for (int d = 0; d < NDUT; d++) begin
      check("rst_hreadyout", 32'(rdy_of(d)), 32'd1);
      check("rst_hresp", 32'(resp_of(d)), 32'd0);
      check("rst_hrdata", rdata_of(d), 32'h0);
      check("rst_state", state_of(d), 32'(ST_IDLE));
    end
    HRESETn = 1'b1;

    // Zero-wait write then read back.
    txq.push_back(mk(2'(NONSEQ), 1'b1, 3'(WORD), 32'h10, 32'hAABB_CCDD));
    txq.push_back(mk(2'(NONSEQ), 1'b0, 3'(WORD), 32'h10, 32'h0));
    run_q(0);

    // Two wait states on both write and read.
    txq.push_back(mk(2'(NONSEQ), 1'b1, 3'(WORD), 32'h10, 32'hAABB_CCDD));
    txq.push_back(mk(2'(NONSEQ), 1'b0, 3'(WORD), 32'h10, 32'h0));
    run_q(1);

    // Byte and halfword lanes merged into one word.
    txq.push_back(mk(2'(NONSEQ), 1'b1, 3'(BYTE), 32'h11, {4{8'h11}}));
    txq.push_back(mk(2'(NONSEQ), 1'b1, 3'(HALF), 32'h12, {2{16'h2233}}));
    txq.push_back(mk(2'(NONSEQ), 1'b0, 3'(WORD), 32'h10, 32'h0));
    run_q(0);

    // Misaligned halfword write errors and leaves memory untouched.
    txq.push_back(mk(2'(NONSEQ), 1'b1, 3'(HALF), 32'h13, 32'hFFFF_FFFF));
    txq.push_back(mk(2'(NONSEQ), 1'b0, 3'(WORD), 32'h10, 32'h0));
    run_q(0);

    // Four-beat INCR write with a BUSY between beats 2 and 3, then read back.
    txq.push_back(mk(2'(NONSEQ), 1'b1, 3'(WORD), 32'h20, 32'h1111_0000));
    txq.push_back(mk(2'(SEQ),    1'b1, 3'(WORD), 32'h24, 32'h2222_0001));
    txq.push_back(mk(2'(BUSY),   1'b1, 3'(WORD), 32'h28, 32'h0));
    txq.push_back(mk(2'(SEQ),    1'b1, 3'(WORD), 32'h28, 32'h3333_0002));
    txq.push_back(mk(2'(SEQ),    1'b1, 3'(WORD), 32'h2C, 32'h4444_0003));
    for (int i = 0; i < 4; i++)
      txq.push_back(mk(2'(NONSEQ), 1'b0, 3'(WORD), 32'h20 + 32'(4*i), 32'h0));
    run_q(1);

    // Top word: privileged write, then a non-privileged read (error only
    // when the privilege check is built in).
    txq.push_back(mk(2'(NONSEQ), 1'b1, 3'(WORD), 32'(4*MEM_DEPTH - 4), 32'h5A5A_A5A5, 4'b0010));
    txq.push_back(mk(2'(NONSEQ), 1'b0, 3'(WORD), 32'(4*MEM_DEPTH - 4), 32'h0, 4'b0000));
    txq.push_back(mk(2'(NONSEQ), 1'b0, 3'(WORD), 32'(4*MEM_DEPTH - 4), 32'h0, 4'b0010));
    txq.push_back(mk(2'(NONSEQ), 1'b0, 3'(WORD), 32'(4*MEM_DEPTH), 32'h0));
    run_q(0);

    // Reset in the second wait cycle of a write aborts it.
    txq.push_back(mk(2'(NONSEQ), 1'b1, 3'(WORD), 32'h40, 32'hCAFE_F00D));
    run_q(2);
    @(negedge HCLK);
    drive_xfer(2, mk(2'(NONSEQ), 1'b1, 3'(WORD), 32'h40, 32'hDEAD_BEEF));
    @(negedge HCLK);
    check("rst_abort_wait1", 32'(hrdy2), 32'd0);
    hwdata = 32'hDEAD_BEEF;
    drive_idle();
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check("rst_abort_hreadyout", 32'(hrdy2), 32'd1);
    check("rst_abort_hresp", 32'(hresp2), 32'd0);
    check("rst_abort_hrdata", hrdata2, 32'h0);
    check("rst_abort_state", 32'(st2), 32'(ST_IDLE));
    @(negedge HCLK);
    HRESETn = 1'b1;
    txq.push_back(mk(2'(NONSEQ), 1'b0, 3'(WORD), 32'h40, 32'h0));
    run_q(2);

    // Randomized traffic on every instance.
    for (int d = 0; d < NDUT; d++) begin
      random_q(80);
      run_q(d);
    end

    repeat (2) @(negedge HCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
